// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with flush/stall, load-use bubble insertion and a saturating bubble counter
module id_ex_reg (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic [12:0] iCtrl,
  input  logic [31:0] iPc,
  input  logic [31:0] iRs1Data,
  input  logic [31:0] iRs2Data,
  input  logic [31:0] iImm,
  input  logic [4:0]  iRs1,
  input  logic [4:0]  iRs2,
  input  logic [4:0]  iRd,
  input  logic [2:0]  iFunct3,
  input  logic        iFunct7b5,
  output logic        oValid,
  output logic [12:0] oCtrl,
  output logic [31:0] oPc,
  output logic [31:0] oRs1Data,
  output logic [31:0] oRs2Data,
  output logic [31:0] oImm,
  output logic [4:0]  oRs1,
  output logic [4:0]  oRs2,
  output logic [4:0]  oRd,
  output logic [2:0]  oFunct3,
  output logic        oFunct7b5,
  output logic        oHazard,
  output logic [15:0] oBubbleCnt
);
  logic        r_valid;
  logic [12:0] r_ctrl;
  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [15:0] r_cnt;
  logic        w_hazard, w_hold, w_bubble, w_load;
  // ctrl bit 10 is MemRd: a load in EX whose rd feeds the instruction in decode
  assign w_hazard = r_valid & r_ctrl[10] & (r_rd != 5'd0) & iValid & ((r_rd == iRs1) | (r_rd == iRs2));
  assign w_hold   = iStall & ~iFlush;
  assign w_bubble = iFlush | (~iStall & w_hazard);
  assign w_load   = iValid & ~w_bubble;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_cnt      <= '0;
    end else if (!w_hold) begin
      r_valid    <= w_load;
      r_ctrl     <= w_load ? iCtrl : '0;
      r_pc       <= iPc;
      r_rs1_data <= iRs1Data;
      r_rs2_data <= iRs2Data;
      r_imm      <= iImm;
      r_rs1      <= iRs1;
      r_rs2      <= iRs2;
      r_rd       <= iRd;
      r_funct3   <= iFunct3;
      r_funct7b5 <= iFunct7b5;
      if (w_bubble && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  assign oValid     = r_valid;
  assign oCtrl      = r_ctrl;
  assign oPc        = r_pc;
  assign oRs1Data   = r_rs1_data;
  assign oRs2Data   = r_rs2_data;
  assign oImm       = r_imm;
  assign oRs1       = r_rs1;
  assign oRs2       = r_rs2;
  assign oRd        = r_rd;
  assign oFunct3    = r_funct3;
  assign oFunct7b5  = r_funct7b5;
  assign oHazard    = w_hazard;
  assign oBubbleCnt = r_cnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed vectors with a scoreboard queue checked by a monitor one step after each clock edge
module tb_id_ex_reg;
  logic        iClk = 1'b0, iRst, iValid, iStall, iFlush, iFunct7b5;
  logic [12:0] iCtrl;
  logic [31:0] iPc, iRs1Data, iRs2Data, iImm;
  logic [4:0]  iRs1, iRs2, iRd;
  logic [2:0]  iFunct3;
  logic        oValid, oFunct7b5, oHazard;
  logic [12:0] oCtrl;
  logic [31:0] oPc, oRs1Data, oRs2Data, oImm;
  logic [4:0]  oRs1, oRs2, oRd;
  logic [2:0]  oFunct3;
  logic [15:0] oBubbleCnt;
  int checks = 0, errors = 0;
  localparam logic [12:0] RT = 13'h0C08, LD = 13'h0404, AL = 13'h0004;
  typedef struct {
    logic        v;
    logic [12:0] c;
    logic [31:0] pc;
    logic [4:0]  s1, s2, d;
    logic        hz;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  id_ex_reg dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iStall(iStall), .iFlush(iFlush),
    .iCtrl(iCtrl), .iPc(iPc), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm),
    .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iFunct3(iFunct3), .iFunct7b5(iFunct7b5),
    .oValid(oValid), .oCtrl(oCtrl), .oPc(oPc), .oRs1Data(oRs1Data), .oRs2Data(oRs2Data),
    .oImm(oImm), .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd), .oFunct3(oFunct3),
    .oFunct7b5(oFunct7b5), .oHazard(oHazard), .oBubbleCnt(oBubbleCnt)
  );
  always #5 iClk = ~iClk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, req);
    end
  endtask
  function automatic exp_t mk(input logic v, input logic [12:0] c, input logic [31:0] pc,
                              input logic [4:0] s1, s2, d, input logic hz, input logic [15:0] cnt);
    exp_t e;
    e.v = v; e.c = c; e.pc = pc; e.s1 = s1; e.s2 = s2; e.d = d; e.hz = hz; e.cnt = cnt;
    return e;
  endfunction
  task automatic drive(input logic v, st, fl, input logic [12:0] c, input logic [31:0] pc,
                       input logic [4:0] s1, s2, d);
    iValid = v; iStall = st; iFlush = fl; iCtrl = c; iPc = pc;
    iRs1Data = pc + 32'd1; iRs2Data = pc + 32'd2; iImm = pc + 32'd3;
    iRs1 = s1; iRs2 = s2; iRd = d; iFunct3 = d[2:0]; iFunct7b5 = d[0];
  endtask
  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge iClk);
    @(negedge iClk);
  endtask
  task automatic rst_chk(input string n);
    chk({n, "_valid"}, 32'(oValid), 32'd0);
    chk({n, "_ctrl"}, 32'(oCtrl), 32'd0);
    chk({n, "_data"}, oPc | oRs1Data | oRs2Data | oImm, 32'd0);
    chk({n, "_idx"}, 32'({oRs1, oRs2, oRd, oFunct3, oFunct7b5}), 32'd0);
    chk({n, "_hazard"}, 32'(oHazard), 32'd0);
    chk({n, "_cnt"}, 32'(oBubbleCnt), 32'd0);
  endtask
  // Monitor: outputs are presented every cycle, so each queued expectation is consumed just after an edge
  initial forever begin
    @(posedge iClk);
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", 32'(oValid), 32'(e.v));
      chk("ctrl", 32'(oCtrl), 32'(e.c));
      chk("hazard", 32'(oHazard), 32'(e.hz));
      chk("bubble_cnt", 32'(oBubbleCnt), 32'(e.cnt));
      if (e.v) begin
        chk("pc", oPc, e.pc);
        chk("rs1_data", oRs1Data, e.pc + 32'd1);
        chk("rs2_data", oRs2Data, e.pc + 32'd2);
        chk("imm", oImm, e.pc + 32'd3);
        chk("idx", 32'({oRs1, oRs2, oRd}), 32'({e.s1, e.s2, e.d}));
        chk("funct", 32'({oFunct3, oFunct7b5}), 32'({e.d[2:0], e.d[0]}));
      end
    end
  end
  initial begin
    iRst = 1'b1;
    drive(0, 0, 0, 13'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    #3 rst_chk("reset");
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    drive(1, 0, 0, RT, 32'h100, 5'd1, 5'd2, 5'd5);
    step(mk(1, RT, 32'h100, 5'd1, 5'd2, 5'd5, 0, 16'd0));
    drive(1, 0, 0, LD, 32'h104, 5'd3, 5'd4, 5'd7);
    step(mk(1, LD, 32'h104, 5'd3, 5'd4, 5'd7, 0, 16'd0));
    drive(1, 0, 0, AL, 32'h108, 5'd1, 5'd7, 5'd8);
    #1 chk("hazard_pre_rs2", 32'(oHazard), 32'd1);
    step(mk(0, 13'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 16'd1));
    step(mk(1, AL, 32'h108, 5'd1, 5'd7, 5'd8, 0, 16'd1));
    drive(1, 0, 0, LD, 32'h10C, 5'd0, 5'd0, 5'd0);
    step(mk(1, LD, 32'h10C, 5'd0, 5'd0, 5'd0, 0, 16'd1));
    drive(1, 0, 0, AL, 32'h110, 5'd0, 5'd0, 5'd9);
    #1 chk("hazard_x0", 32'(oHazard), 32'd0);
    step(mk(1, AL, 32'h110, 5'd0, 5'd0, 5'd9, 0, 16'd1));
    drive(1, 0, 0, LD, 32'h114, 5'd1, 5'd2, 5'd7);
    step(mk(1, LD, 32'h114, 5'd1, 5'd2, 5'd7, 0, 16'd1));
    drive(1, 1, 0, AL, 32'h118, 5'd7, 5'd0, 5'd10);
    for (int i = 0; i < 3; i++) step(mk(1, LD, 32'h114, 5'd1, 5'd2, 5'd7, 1, 16'd1));
    drive(1, 1, 1, AL, 32'h118, 5'd7, 5'd0, 5'd10);
    step(mk(0, 13'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 16'd2));
    drive(1, 0, 0, AL, 32'h118, 5'd7, 5'd0, 5'd10);
    step(mk(1, AL, 32'h118, 5'd7, 5'd0, 5'd10, 0, 16'd2));
    drive(0, 0, 0, RT, 32'h11C, 5'd1, 5'd2, 5'd11);
    step(mk(0, 13'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 16'd2));
    drive(1, 0, 1, RT, 32'h120, 5'd1, 5'd2, 5'd12);
    step(mk(0, 13'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 16'd3));
    drive(1, 0, 0, LD, 32'h124, 5'd0, 5'd0, 5'd7);
    step(mk(1, LD, 32'h124, 5'd0, 5'd0, 5'd7, 0, 16'd3));
    drive(1, 0, 0, AL, 32'h128, 5'd7, 5'd0, 5'd13);
    #1 chk("hazard_pre_rs1", 32'(oHazard), 32'd1);
    #1 iRst = 1'b1;
    #1 rst_chk("async_reset");
    @(negedge iClk);
    iRst = 1'b0;
    step(mk(1, AL, 32'h128, 5'd7, 5'd0, 5'd13, 0, 16'd0));
    drive(1, 0, 1, RT, 32'h200, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 65534; i++) @(negedge iClk);
    for (int i = 0; i < 3; i++) step(mk(0, 13'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 16'hFFFF));
    drive(1, 0, 0, RT, 32'h204, 5'd1, 5'd2, 5'd3);
    step(mk(1, RT, 32'h204, 5'd1, 5'd2, 5'd3, 0, 16'hFFFF));
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
